// File: rtl/mat_addsub_engine.sv
// Streaming matrix add/subtract over IEEE-754 doubles, LANES double_adder lanes per beat; optional exc flag under MATADD_EXC_EN.
// Latency: 1 accept cycle + double_adder latency + 1 output cycle per beat; done one cycle after the final output handshake.
// Backpressure: in_ready only in ACCEPT; out_valid and c hold until out_ready; the adders are stalled via their stb/ack handshakes.

module double_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [63:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [63:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    // Double-precision adder, round-to-nearest-even, denormal aware.
    // Latency: 4 cycles from operand b taken to output_z_stb; holds the result until output_z_ack.

    typedef enum logic [2:0] {GET_A, GET_B, ALIGN, ADD, PACK, PUT_Z} add_state_t;

    add_state_t  st_q;
    logic [63:0] a_q, b_q, z_q, spec_z_q;
    logic        spec_q, xs_q, ys_q, sum_s_q;
    logic [10:0] xe_q;
    logic [55:0] xm_q, ym_q, sum_m_q;
    logic [11:0] sum_e_q;

    logic [10:0] ea, eb, eae, ebe, d, al_xe;
    logic [52:0] ma, mb, mx;
    logic [55:0] yext, ysh;
    logic        nan_a, nan_b, inf_a, inf_b, a_big, ysticky, al_spec, al_xs, al_ys;
    logic [63:0] al_z;

    always_comb begin
        ea      = a_q[62:52];
        eb      = b_q[62:52];
        eae     = (ea == 11'd0) ? 11'd1 : ea;
        ebe     = (eb == 11'd0) ? 11'd1 : eb;
        ma      = {ea != 11'd0, a_q[51:0]};
        mb      = {eb != 11'd0, b_q[51:0]};
        nan_a   = (ea == 11'h7FF) && (a_q[51:0] != 52'd0);
        nan_b   = (eb == 11'h7FF) && (b_q[51:0] != 52'd0);
        inf_a   = (ea == 11'h7FF) && (a_q[51:0] == 52'd0);
        inf_b   = (eb == 11'h7FF) && (b_q[51:0] == 52'd0);
        al_spec = 1'b1;
        al_z    = 64'h7FF8_0000_0000_0000;
        if (nan_a || nan_b || (inf_a && inf_b && (a_q[63] != b_q[63]))) al_z = 64'h7FF8_0000_0000_0000;
        else if (inf_a) al_z = a_q;
        else if (inf_b) al_z = b_q;
        else al_spec = 1'b0;
        // X always carries the larger magnitude so an effective subtract never goes negative.
        a_big   = (eae > ebe) || ((eae == ebe) && (ma >= mb));
        al_xs   = a_big ? a_q[63] : b_q[63];
        al_ys   = a_big ? b_q[63] : a_q[63];
        al_xe   = a_big ? eae : ebe;
        mx      = a_big ? ma : mb;
        d       = a_big ? (eae - ebe) : (ebe - eae);
        yext    = {(a_big ? mb : ma), 3'b000};
        ysh     = yext >> d;
        ysticky = (ysh << d) != yext;
    end

    logic        eff_sub, ns;
    logic [56:0] sum;
    logic [5:0]  lz;
    logic [10:0] sh;
    logic [55:0] nm;
    logic [11:0] ne;

    always_comb begin
        eff_sub = xs_q ^ ys_q;
        sum     = eff_sub ? ({1'b0, xm_q} - {1'b0, ym_q}) : ({1'b0, xm_q} + {1'b0, ym_q});
        lz      = 6'd56;
        for (int i = 0; i < 56; i++) begin
            if (sum[i]) lz = 6'(55 - i);
        end
        // Left shift is capped so the exponent bottoms out at 1 (denormal result).
        sh = ({5'd0, lz} < xe_q) ? {5'd0, lz} : (xe_q - 11'd1);
        if (sum[56]) begin
            nm = {sum[56:2], sum[1] | sum[0]};
            ne = {1'b0, xe_q} + 12'd1;
        end else begin
            nm = sum[55:0] << sh;
            ne = {1'b0, xe_q} - {1'b0, sh};
        end
        ns = (sum == 57'd0) ? (xs_q & ~eff_sub) : xs_q;
    end

    logic [52:0] m53, mf;
    logic [53:0] mr;
    logic [11:0] ef;
    logic        rnd_up;
    logic [63:0] pz;

    always_comb begin
        m53    = sum_m_q[55:3];
        rnd_up = sum_m_q[2] & (sum_m_q[1] | sum_m_q[0] | m53[0]);
        mr     = {1'b0, m53} + {53'd0, rnd_up};
        if (mr[53]) begin
            mf = mr[53:1];
            ef = sum_e_q + 12'd1;
        end else begin
            mf = mr[52:0];
            ef = sum_e_q;
        end
        if (spec_q) pz = spec_z_q;
        else if (ef >= 12'h7FF) pz = {sum_s_q, 11'h7FF, 52'd0};
        else pz = {sum_s_q, (mf[52] ? ef[10:0] : 11'd0), mf[51:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= GET_A;
            a_q      <= '0;
            b_q      <= '0;
            z_q      <= '0;
            spec_q   <= 1'b0;
            spec_z_q <= '0;
            xs_q     <= 1'b0;
            ys_q     <= 1'b0;
            xe_q     <= '0;
            xm_q     <= '0;
            ym_q     <= '0;
            sum_s_q  <= 1'b0;
            sum_e_q  <= '0;
            sum_m_q  <= '0;
        end else begin
            case (st_q)
                GET_A: if (input_a_stb) begin
                    a_q  <= input_a;
                    st_q <= GET_B;
                end
                GET_B: if (input_b_stb) begin
                    b_q  <= input_b;
                    st_q <= ALIGN;
                end
                ALIGN: begin
                    spec_q   <= al_spec;
                    spec_z_q <= al_z;
                    xs_q     <= al_xs;
                    ys_q     <= al_ys;
                    xe_q     <= al_xe;
                    xm_q     <= {mx, 3'b000};
                    ym_q     <= {ysh[55:1], ysh[0] | ysticky};
                    st_q     <= ADD;
                end
                ADD: begin
                    sum_s_q <= ns;
                    sum_e_q <= ne;
                    sum_m_q <= nm;
                    st_q    <= PACK;
                end
                PACK: begin
                    z_q  <= pz;
                    st_q <= PUT_Z;
                end
                PUT_Z: if (output_z_ack) st_q <= GET_A;
                default: st_q <= GET_A;
            endcase
        end
    end

    assign input_a_ack  = (st_q == GET_A);
    assign input_b_ack  = (st_q == GET_B);
    assign output_z_stb = (st_q == PUT_Z);
    assign output_z     = z_q;

endmodule

module mat_addsub_engine #(
    parameter int LANES = 2,
    parameter int ELEMS = 16,
    parameter int DW    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] a,
    input  logic [LANES*DW-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] c,
    output logic                last,
`ifdef MATADD_EXC_EN
    output logic                exc,
`endif
    output logic                done
);

    localparam int BEATS = ELEMS / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (ELEMS % LANES != 0) begin : g_bad_elems
        $error("mat_addsub_engine: ELEMS must be a multiple of LANES");
    end
    if (DW != 64) begin : g_bad_dw
        $error("mat_addsub_engine: DW must be 64");
    end

    typedef enum logic [1:0] {IDLE, ACCEPT, ISSUE, OUT} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              sub_q, sub_d, done_q, done_d;
    logic [DW-1:0]     add_in1 [LANES];
    logic [DW-1:0]     add_in2 [LANES];
    logic [DW-1:0]     z_dat   [LANES];
    logic [LANES-1:0]  a_stb, b_stb, a_ack, b_ack, z_vld, z_ack;
    logic [LANES-1:0]  ack_seen, res_seen, cap;
    logic [LANES*DW-1:0] c_q;
    logic              accept, all_res;

    assign accept = (state_q == ACCEPT) && in_valid;

    // A lane result is taken once, only after both operands were handed over this beat.
    always_comb begin
        cap = '0;
        for (int j = 0; j < LANES; j++) begin
            cap[j] = (state_q == ISSUE) && z_vld[j] && !res_seen[j] && ack_seen[j];
        end
    end
    assign all_res = &(res_seen | cap);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        sub_d   = sub_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                sub_d   = sub;
                beat_d  = '0;
                state_d = ACCEPT;
            end
            ACCEPT: if (in_valid) state_d = ISSUE;
            ISSUE:  if (all_res) state_d = OUT;
            OUT: if (out_ready) begin
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    beat_d  = beat_q + 1'b1;
                    state_d = ACCEPT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            sub_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            sub_q   <= sub_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_stb    <= '0;
            b_stb    <= '0;
            z_ack    <= '0;
            ack_seen <= '0;
            res_seen <= '0;
            c_q      <= '0;
            for (int j = 0; j < LANES; j++) begin
                add_in1[j] <= '0;
                add_in2[j] <= '0;
            end
        end else begin
            for (int j = 0; j < LANES; j++) begin
                z_ack[j] <= 1'b0;
                if (accept) begin
                    add_in1[j]  <= a[j*DW +: DW];
                    add_in2[j]  <= {b[j*DW + DW - 1] ^ sub_q, b[j*DW +: DW-1]};
                    a_stb[j]    <= 1'b1;
                    b_stb[j]    <= 1'b1;
                    ack_seen[j] <= 1'b0;
                    res_seen[j] <= 1'b0;
                end else begin
                    if (a_stb[j] && a_ack[j]) a_stb[j] <= 1'b0;
                    if (b_stb[j] && b_ack[j]) begin
                        b_stb[j]    <= 1'b0;
                        ack_seen[j] <= 1'b1;
                    end
                    if (cap[j]) begin
                        c_q[j*DW +: DW] <= z_dat[j];
                        z_ack[j]        <= 1'b1;
                        res_seen[j]     <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        double_adder u_add (
            .clk          (clk),
            .rst          (rst),
            .input_a      (add_in1[j]),
            .input_a_stb  (a_stb[j]),
            .input_a_ack  (a_ack[j]),
            .input_b      (add_in2[j]),
            .input_b_stb  (b_stb[j]),
            .input_b_ack  (b_ack[j]),
            .output_z     (z_dat[j]),
            .output_z_stb (z_vld[j]),
            .output_z_ack (z_ack[j])
        );
    end

`ifdef MATADD_EXC_EN
    logic             exc_q;
    logic [LANES-1:0] cap_inf;

    always_comb begin
        cap_inf = '0;
        for (int j = 0; j < LANES; j++) begin
            cap_inf[j] = cap[j] && (z_dat[j][62:52] == 11'h7FF);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) exc_q <= 1'b0;
        else if ((state_q == IDLE) && start) exc_q <= 1'b0;
        else if (|cap_inf) exc_q <= 1'b1;
    end

    assign exc = exc_q;
`endif

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == ACCEPT);
    assign out_valid = (state_q == OUT);
    assign last      = (state_q == OUT) && (beat_q == LAST_BEAT);
    assign done      = done_q;
    assign c         = c_q;

endmodule

// File: tb/tb_mat_addsub_engine.sv
// Directed bench for mat_addsub_engine (LANES=2, ELEMS=4): add, subtract, stalls, reset, ignored start, exc.
module tb_mat_addsub_engine;

    localparam int LANES = 2;
    localparam int DW    = 64;

    localparam logic [63:0] D_0P25 = 64'h3FD0_0000_0000_0000;
    localparam logic [63:0] D_0P5  = 64'h3FE0_0000_0000_0000;
    localparam logic [63:0] D_0P75 = 64'h3FE8_0000_0000_0000;
    localparam logic [63:0] D_1    = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D_M1   = 64'hBFF0_0000_0000_0000;
    localparam logic [63:0] D_2    = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D_3    = 64'h4008_0000_0000_0000;
    localparam logic [63:0] D_4    = 64'h4010_0000_0000_0000;
    localparam logic [63:0] D_5    = 64'h4014_0000_0000_0000;
    localparam logic [63:0] D_INF  = 64'h7FF0_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, sub = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [LANES*DW-1:0] a = '0, b = '0;
    logic busy, in_ready, out_valid, last, done;
    logic [LANES*DW-1:0] c;
`ifdef MATADD_EXC_EN
    logic exc;
`endif

    int compared = 0;
    int mismatched = 0;

    mat_addsub_engine #(.LANES(LANES), .ELEMS(4), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .last      (last),
`ifdef MATADD_EXC_EN
        .exc       (exc),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic start_burst(input logic s);
        start = 1'b1;
        sub   = s;
        tick();
        start = 1'b0;
        sub   = ~s;
    endtask

    task automatic send(input string tag, input logic [127:0] av, input logic [127:0] bv);
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk1({tag, "_busy"}, busy, 1'b1);
        chk1({tag, "_in_ready_low"}, in_ready, 1'b0);
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk1({tag, "_out_valid"}, out_valid, 1'b1);
    endtask

    task automatic take(input string tag, input logic [127:0] exp_c, input logic exp_last);
        chk({tag, "_c"}, c, exp_c);
        chk1({tag, "_last"}, last, exp_last);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (exp_last) begin
            chk1({tag, "_done"}, done, 1'b1);
            chk1({tag, "_busy_end"}, busy, 1'b0);
            tick();
            chk1({tag, "_done_pulse"}, done, 1'b0);
        end else begin
            chk1({tag, "_next_ready"}, in_ready, 1'b1);
        end
    endtask

    initial begin
        logic extra_done;

        tick();
        tick();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_last", last, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk("rst_c", c, 128'd0);
`ifdef MATADD_EXC_EN
        chk1("rst_exc", exc, 1'b0);
`endif
        rst = 1'b0;
        tick();
        chk1("idle_in_ready", in_ready, 1'b0);

        // Add: 1+2 on both lanes, then 2+2 on both lanes.
        start_burst(1'b0);
        chk1("add_busy", busy, 1'b1);
        send("add_b0", {D_1, D_1}, {D_2, D_2});
        wait_out("add_b0");
        take("add_b0", {D_3, D_3}, 1'b0);
        send("add_b1", {D_2, D_2}, {D_2, D_2});
        wait_out("add_b1");
        take("add_b1", {D_4, D_4}, 1'b1);

        // Subtract with sub toggled after the start cycle.
        start_burst(1'b1);
        send("sub_b0", {D_1, D_5}, {D_2, D_2});
        sub = 1'b1;
        wait_out("sub_b0");
        take("sub_b0", {D_M1, D_3}, 1'b0);
        sub = 1'b0;
        send("sub_b1", {D_5, D_5}, {D_2, D_2});
        wait_out("sub_b1");
        take("sub_b1", {D_3, D_3}, 1'b1);

        // Output stall on beat 1, then an input gap before beat 2.
        start_burst(1'b0);
        send("bp_b0", {D_1, D_1}, {D_2, D_2});
        wait_out("bp_b0");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("bp_stall_valid", out_valid, 1'b1);
            chk("bp_stall_c", c, {D_3, D_3});
        end
        take("bp_b0", {D_3, D_3}, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("bp_gap_ready", in_ready, 1'b1);
        end
        send("bp_b1", {D_1, D_0P5}, {D_M1, D_0P25});
        wait_out("bp_b1");
        take("bp_b1", {64'd0, D_0P75}, 1'b1);

        // Reset while the adders are working on beat 1.
        start_burst(1'b0);
        send("rst_mid", {D_1, D_1}, {D_2, D_2});
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_c", c, 128'd0);
        for (int i = 0; i < 10; i++) tick();
        chk1("rst_mid_no_stale", out_valid, 1'b0);
        start_burst(1'b0);
        send("post_rst_b0", {D_2, D_1}, {D_2, D_2});
        wait_out("post_rst_b0");
        take("post_rst_b0", {D_4, D_3}, 1'b0);
        send("post_rst_b1", {D_1, D_2}, {D_2, D_2});
        wait_out("post_rst_b1");
        take("post_rst_b1", {D_3, D_4}, 1'b1);

        // start (with sub=1) pulsed mid-burst must be ignored.
        start_burst(1'b0);
        send("ign_b0", {D_1, D_1}, {D_2, D_2});
        start = 1'b1;
        sub   = 1'b1;
        tick();
        start = 1'b0;
        sub   = 1'b0;
        wait_out("ign_b0");
        take("ign_b0", {D_3, D_3}, 1'b0);
        send("ign_b1", {D_2, D_2}, {D_2, D_2});
        wait_out("ign_b1");
        take("ign_b1", {D_4, D_4}, 1'b1);
        extra_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            extra_done = extra_done | done;
        end
        chk1("ign_single_done", extra_done, 1'b0);
        chk1("ign_idle", busy, 1'b0);

`ifdef MATADD_EXC_EN
        // +Inf on lane 1 sets the sticky flag until the next accepted start.
        start_burst(1'b0);
        chk1("exc_clear0", exc, 1'b0);
        send("exc_b0", {D_INF, D_1}, {D_1, D_2});
        wait_out("exc_b0");
        chk1("exc_set", exc, 1'b1);
        take("exc_b0", {D_INF, D_3}, 1'b0);
        send("exc_b1", {D_1, D_1}, {D_2, D_2});
        wait_out("exc_b1");
        take("exc_b1", {D_3, D_3}, 1'b1);
        chk1("exc_held", exc, 1'b1);
        start_burst(1'b0);
        chk1("exc_cleared", exc, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mat_addsub_engine.md
# mat_addsub_engine

Parametrised streaming matrix add/subtract engine for IEEE-754 double elements. It generalises the fixed 4x4 adder to any element count, number of parallel lanes, and add or subtract mode. A matrix is processed as a burst of beats, each carrying LANES elements per operand, with valid/ready handshakes on both sides and a done pulse at burst end. It sits between the operand fetch stage and the result writeback stage. Each lane uses one existing `double_adder` instance driven through its stb/ack handshake.

## Interface
- LANES, 2, parallel `double_adder` lanes per beat
- ELEMS, 16, matrix elements per burst (4x4); must be a multiple of LANES, otherwise elaboration fails via `$error`
- DW, 64, element width; fixed at 64 (double)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock clk
- start  in  1  burst start; honoured only in IDLE
- sub  in  1  mode, sampled with start: 0 = c=a+b, 1 = c=a-b
- busy  out  1  high from the cycle after accepted start until done
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine can accept an operand beat
- a, b  in  LANES*DW  operands; lane j = [j*DW +: DW]
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result beat
- c  out  LANES*DW  results, same lane packing as a and b
- last  out  1  high with out_valid on the final beat
- done  out  1  one-cycle pulse after the final output handshake
- exc  out  1  sticky exception flag (only when MATADD_EXC_EN is defined)

## Operation
- BEATS = ELEMS/LANES. The beat counter is max(1,$clog2(BEATS)) bits wide. Element index = beat*LANES + j.
- FSM states: IDLE, ACCEPT, ISSUE, OUT.
- IDLE: in_ready=0, out_valid=0, busy=0. On start: latch sub, clear beat, go to ACCEPT.
- ACCEPT: in_ready=1. When in_valid&in_ready:
  - Register a into each lane's add_in1.
  - Register b into add_in2. If sub=1, invert b lane bit 63 first.
  - Set every a_stb/b_stb, clear per-lane ack_seen and res_seen flags, go to ISSUE.
- ISSUE, per lane, independently:
  - Drop a_stb on input_a_ack and b_stb on input_b_ack.
  - On output_z_stb: capture output_z into the c lane, pulse output_z_ack for one cycle, set res_seen.
- ISSUE exit: when all res_seen bits are set (combinational AND across lanes, evaluated in the same cycle), go to OUT.
- OUT: out_valid=1, and last=1 when beat==BEATS-1. On out_ready:
  - If this is the last beat, go to IDLE and pulse done.
  - Otherwise beat++ and go to ACCEPT.
- c holds its value from capture until the next capture. It never changes while out_valid=1.
- start outside IDLE is ignored. sub is ignored except in the start cycle.
- Lanes may complete in any order and in different cycles. A lane's result is captured exactly once per beat.

## Timing
- Reset values:
  - State IDLE; busy, in_ready, out_valid, last, done, exc = 0.
  - c = 0; all add_in1/add_in2 = 0; all stb/ack = 0; beat = 0.
- start in cycle t: busy=1 and in_ready=1 at t+1.
- Input handshake in cycle t: stbs high at t+1. Adder latency is set by `double_adder` and is not fixed here.
- Last lane result captured in cycle t: out_valid=1 at t+1.
- Output handshake on a non-final beat in cycle t: in_ready=1 at t+1.
- Output handshake on the final beat in cycle t: done=1 and busy=0 at t+1, for one cycle only.
- in_valid held high in ACCEPT accepts on the first cycle. out_ready held high consumes a result on the first out_valid cycle.
- rst at any point (mid-ISSUE, mid-OUT) returns to IDLE next cycle with the reset values above. The adders share rst, so no stale result is reported afterwards. In-flight data is discarded.
- Minimum burst: BEATS × (1 accept + adder latency + 1 out) cycles.

## Configuration
- MATADD_EXC_EN defined:
  - The exc port exists.
  - exc is set when any captured lane result has exponent bits [62:52] == 11'h7FF (Inf/NaN).
  - exc stays set until the next accepted start, which clears it.
- MATADD_EXC_EN undefined: the exc port and its logic are absent; all other behaviour is identical.

## Test plan
- Add, LANES=2, ELEMS=4:
  - Stimulus: all a = 0x3FF0000000000000 (1.0), all b = 0x4000000000000000 (2.0).
  - Response: 2 result beats, every lane 0x4008000000000000 (3.0); last on beat 2; done one cycle after the final handshake.
- Subtract:
  - Stimulus: sub=1, a = 0x4014000000000000 (5.0), b = 0x4000000000000000 (2.0).
  - Response: every lane 0x4008000000000000 (3.0). Changing sub mid-burst has no effect.
- Backpressure and idle gaps:
  - Stimulus: out_ready low for 10 cycles on beat 1; in_valid low for 5 cycles before beat 2.
  - Response: out_valid and c held stable during the stall, in_ready held high during the gap, and results still correct.
- Reset mid-operation:
  - Stimulus: rst during ISSUE of beat 1.
  - Response: next cycle busy=0, out_valid=0, c=0. A new burst then completes correctly.
- Ignored start:
  - Stimulus: start pulsed while busy=1.
  - Response: the burst is unaffected, beat count unchanged, exactly one done.
- Exception flag (MATADD_EXC_EN):
  - Stimulus: lane 1 a = 0x7FF0000000000000 (+Inf), b = 1.0.
  - Response: exc=1 after capture, held through done, cleared on the next start.
